// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
//   Sequential radix-4 Booth multiplier. Each CALC cycle retires two multiplier bits,
//   so a signed WIDTH x WIDTH product takes WIDTH/2 steps. The result goes to
//   product_hi/product_lo for the ALU HI/LO registers.
//   Optional feature macro: UNSIGNED_MODE_EN. It adds the is_unsigned input. When that
//   input is set, the operands are zero-extended and one extra step is run.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef UNSIGNED_MODE_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  // Partial sums are WIDTH+2 bits wide. This covers +/-2A when A is the most-negative
  // value, and also covers an unsigned A zero-extended by two bits.
  localparam int XW  = WIDTH + 2;
  localparam int N_S = WIDTH / 2;
  localparam int CW  = $clog2(N_S + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [XW-1:0]   r_a;          // multiplicand, extended to XW bits
  logic [XW-1:0]   r_acc;        // high part of the running product
  logic [XW-1:0]   r_mq;         // multiplier bits still to consume; the top holds retired product bits
  logic            r_bm1;        // Booth b[-1] bit carried between steps
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_last;       // index of the final step: N-1
  logic            r_unsigned;

  logic            w_unsigned;
  logic            w_accept;
  logic            w_last_step;
  logic [XW-1:0]   w_a_ext;
  logic [XW-1:0]   w_b_ext;
  logic [XW-1:0]   w_a2;
  logic [XW-1:0]   w_pp;
  logic [XW-1:0]   w_sum;
  logic [XW-1:0]   w_next_acc;
  logic [XW-1:0]   w_next_mq;
  logic [2*WIDTH-1:0] w_prod;

`ifdef UNSIGNED_MODE_EN
  assign w_unsigned = is_unsigned;
`else
  assign w_unsigned = 1'b0;
`endif

  // Operands are accepted only outside CALC. A start pulse during CALC is dropped.
  assign w_accept    = start && (r_state != S_CALC);
  assign w_last_step = (r_state == S_CALC) && (r_count == r_last);

  assign w_a_ext = w_unsigned ? {2'b00, multiplicand}
                              : {{2{multiplicand[WIDTH-1]}}, multiplicand};
  assign w_b_ext = w_unsigned ? {2'b00, multiplier}
                              : {{2{multiplier[WIDTH-1]}}, multiplier};

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status decode
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last_step) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = start ? S_CALC : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Booth digit select from {b[2i+1], b[2i], b[2i-1]}
  assign w_a2 = {r_a[XW-2:0], 1'b0};
  always_comb begin
    w_pp = '0;
    case ({r_mq[1:0], r_bm1})
      3'b001, 3'b010: w_pp = r_a;
      3'b011:         w_pp = w_a2;
      3'b100:         w_pp = '0 - w_a2;
      3'b101, 3'b110: w_pp = '0 - r_a;
      default:        w_pp = '0;
    endcase
  end

  // Add the partial product, then shift {acc, mq} right arithmetically by two.
  assign w_sum      = r_acc + w_pp;
  assign w_next_acc = {{2{w_sum[XW-1]}}, w_sum[XW-1:2]};
  assign w_next_mq  = {w_sum[1:0], r_mq[XW-1:2]};

  // After the last shift, the low 2N product bits sit at the top of mq.
  // The high bits sit in acc.
  always_comb begin
    if (r_unsigned) begin
      w_prod = {w_next_acc[WIDTH-3:0], w_next_mq};
    end else begin
      w_prod = {w_next_acc[WIDTH-1:0], w_next_mq[XW-1:2]};
    end
  end

  // Datapath: load operands on accept, then run one radix-4 step per CALC cycle
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_a        <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_bm1      <= 1'b0;
      r_count    <= '0;
      r_last     <= '0;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_a        <= w_a_ext;
      r_acc      <= '0;
      r_mq       <= w_b_ext;
      r_bm1      <= 1'b0;
      r_count    <= '0;
      r_unsigned <= w_unsigned;
      r_last     <= w_unsigned ? CW'(N_S) : CW'(N_S - 1);
    end else if (r_state == S_CALC) begin
      r_acc      <= w_next_acc;
      r_mq       <= w_next_mq;
      r_bm1      <= r_mq[1];
      r_count    <= r_count + 1'b1;
    end
  end

  // Result registers: they change only when an operation completes
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      product_hi <= '0;
      product_lo <= '0;
    end else if (w_last_step) begin
      product_hi <= w_prod[2*WIDTH-1:WIDTH];
      product_lo <= w_prod[WIDTH-1:0];
    end
  end

endmodule
